// File: rtl/dwt_level_scheduler_pkg.sv
// Shared parameters, FSM encoding and length helper for the DWT level scheduler.
// Imported by dwt_pingpong_ram and dwt_level_scheduler.
package dwt_level_scheduler_pkg;

    localparam int MAX_LEN    = 256;
    localparam int LEN_W      = 9;
    localparam int MAX_LEVELS = 4;
    localparam int LVL_W      = 3;
    localparam int TAPS       = 20;
    localparam int DATA_W     = 32;
    localparam int AW         = $clog2(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FEED,
        S_DRAIN,
        S_NEXT,
        S_FLUSH
    } state_t;

    // Decimated output count of one level: (N + TAPS - 1) / 2.
    function automatic logic [LEN_W-1:0] out_len(input logic [LEN_W-1:0] n);
        return LEN_W'(({1'b0, n} + (LEN_W+1)'(TAPS - 1)) >> 1);
    endfunction

endpackage

// File: rtl/dwt_pingpong_ram.sv
// Two-bank coefficient store: one write port, one registered read port.
// Ports: CLK; we/wr_bank/wr_addr/wr_data write; rd_bank/rd_addr in, rd_data out one cycle later.
module dwt_pingpong_ram
    import dwt_level_scheduler_pkg::*;
(
    input  logic              CLK,
    input  logic              we,
    input  logic              wr_bank,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_bank,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:2*MAX_LEN-1];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
        rd_data <= mem[{rd_bank, rd_addr}];
    end

endmodule

// File: rtl/dwt_level_scheduler.sv
// Multi-level DWT sequencer around one shared lo/hi convolution pair.
// Ports: CLK/RST_N (sync, active-low); start/frame_len/levels command; s_* level-0 sample stream;
//   conv_en/conv_rst/conv_data to the pair, lo_data/hi_data/conv_parity from it;
//   m_* coefficient stream (level tag, approx flag, last flag); busy; sticky err.
//   DWT_SCHED_PERF_EN adds perf_cycles and perf_stall counters.
module dwt_level_scheduler
    import dwt_level_scheduler_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic [LVL_W-1:0]  levels,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              conv_en,
    output logic              conv_rst,
    output logic [DATA_W-1:0] conv_data,
    input  logic [DATA_W-1:0] lo_data,
    input  logic [DATA_W-1:0] hi_data,
    input  logic              conv_parity,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [LVL_W-1:0]  m_level,
    output logic              m_approx,
    output logic              m_last,
`ifdef DWT_SCHED_PERF_EN
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stall,
`endif
    output logic              busy,
    output logic              err
);

    state_t state, state_nx;

    logic [LEN_W-1:0]  n_len;
    logic [LEN_W-1:0]  o_len;
    logic [LEN_W-1:0]  tot_len;
    logic [LVL_W-1:0]  lv_cnt;
    logic [LVL_W-1:0]  lvl;
    logic              sel;
    logic [LEN_W-1:0]  feed_cnt;
    logic [LEN_W-1:0]  cap_cnt;
    logic [LEN_W-1:0]  wr_cnt;
    logic [LEN_W-1:0]  fl_idx;
    logic              fl_ok;
    logic              cap_full;
    logic [DATA_W-1:0] cap_lo;
    logic              en_d;

    logic              args_ok;
    logic              lvl_last;
    logic              acc;
    logic              cap_go;

    logic              ram_we;
    logic              rd_bank;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;

    assign o_len    = out_len(n_len);
    assign tot_len  = n_len + LEN_W'(TAPS - 1);
    assign lvl_last = (lvl == lv_cnt - LVL_W'(1));
    assign acc      = m_valid && m_ready;
    assign busy     = (state != S_IDLE);

    assign args_ok = (frame_len >= LEN_W'(TAPS))
                  && (frame_len <= LEN_W'(MAX_LEN))
                  && (levels != '0)
                  && (levels <= LVL_W'(MAX_LEVELS));

    // Only a freshly produced output (pair advanced last cycle) may be
    // captured; the parity level persists while the pair is frozen.
    assign cap_go = en_d && conv_parity && !cap_full && (cap_cnt < o_len);

    dwt_pingpong_ram u_ram (
        .CLK     (CLK),
        .we      (ram_we),
        .wr_bank (~sel),
        .wr_addr (wr_cnt[AW-1:0]),
        .wr_data (cap_lo),
        .rd_bank (rd_bank),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        conv_en   = 1'b0;
        conv_rst  = 1'b0;
        s_ready   = 1'b0;
        conv_data = '0;
        ram_we    = 1'b0;
        rd_bank   = sel;
        rd_addr   = '0;
        unique case (state)
            S_IDLE: begin
                conv_rst = 1'b1;
                if (start && args_ok) begin
                    state_nx = S_CLR;
                end
            end
            S_CLR: begin
                conv_rst = 1'b1;
                state_nx = S_FEED;
            end
            S_FEED: begin
                if (lvl == '0) begin
                    conv_en   = !cap_full && s_valid;
                    s_ready   = conv_en;
                    conv_data = s_data;
                end else begin
                    conv_en   = !cap_full;
                    conv_data = rd_data;
                end
                // Read port has one cycle latency: present the next index.
                rd_addr = feed_cnt[AW-1:0] + AW'(conv_en);
                ram_we  = acc;
                if (conv_en && (feed_cnt == n_len - LEN_W'(1))) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                conv_en = !cap_full && (feed_cnt < tot_len);
                ram_we  = acc;
                if (wr_cnt == o_len) begin
                    state_nx = S_NEXT;
                end
            end
            S_NEXT: begin
                state_nx = lvl_last ? S_FLUSH : S_CLR;
            end
            S_FLUSH: begin
                rd_bank = ~sel;
                rd_addr = fl_idx[AW-1:0];
                if (acc && m_last) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            err      <= 1'b0;
            n_len    <= '0;
            lv_cnt   <= '0;
            lvl      <= '0;
            sel      <= 1'b0;
            feed_cnt <= '0;
            cap_cnt  <= '0;
            wr_cnt   <= '0;
            fl_idx   <= '0;
            fl_ok    <= 1'b0;
            cap_full <= 1'b0;
            cap_lo   <= '0;
            en_d     <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_level  <= '0;
            m_approx <= 1'b0;
            m_last   <= 1'b0;
        end else begin
            en_d <= conv_en;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        err <= !args_ok;
                        if (args_ok) begin
                            n_len  <= frame_len;
                            lv_cnt <= levels;
                            lvl    <= '0;
                            sel    <= 1'b0;
                        end
                    end
                end
                S_CLR: begin
                    feed_cnt <= '0;
                    cap_cnt  <= '0;
                    wr_cnt   <= '0;
                    cap_full <= 1'b0;
                end
                S_FEED, S_DRAIN: begin
                    if (conv_en) begin
                        feed_cnt <= feed_cnt + LEN_W'(1);
                    end
                    if (cap_go) begin
                        cap_full <= 1'b1;
                        cap_cnt  <= cap_cnt + LEN_W'(1);
                        cap_lo   <= lo_data;
                        m_valid  <= 1'b1;
                        m_data   <= hi_data;
                        m_level  <= lvl;
                        m_approx <= 1'b0;
                        m_last   <= 1'b0;
                    end else if (acc) begin
                        m_valid  <= 1'b0;
                        cap_full <= 1'b0;
                        wr_cnt   <= wr_cnt + LEN_W'(1);
                    end
                end
                S_NEXT: begin
                    n_len  <= o_len;
                    fl_idx <= '0;
                    fl_ok  <= 1'b0;
                    // Final level keeps its bank so FLUSH reads the write bank.
                    if (!lvl_last) begin
                        lvl <= lvl + LVL_W'(1);
                        sel <= ~sel;
                    end
                end
                S_FLUSH: begin
                    if (acc) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                    end else if (!m_valid) begin
                        // fl_ok marks rd_data as matching fl_idx.
                        if (fl_ok) begin
                            m_valid  <= 1'b1;
                            m_data   <= rd_data;
                            m_level  <= lvl;
                            m_approx <= 1'b1;
                            m_last   <= (fl_idx == n_len - LEN_W'(1));
                            fl_idx   <= fl_idx + LEN_W'(1);
                            fl_ok    <= 1'b0;
                        end else begin
                            fl_ok <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef DWT_SCHED_PERF_EN
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if (state == S_IDLE && start && args_ok) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if (busy) begin
            perf_cycles <= perf_cycles + 32'd1;
            if (!conv_en) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
